// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Purpose : Round-robin sharing of one UART transmitter among NREQ requesters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int DBIT     = 8,
  parameter int TO_TICKS = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] din,
  input  logic                 s_tick,
  input  logic                 tx_din_done,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic                 busy
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CW   = $clog2(TO_TICKS + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TO_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_state;
  logic [IDXW-1:0]   r_last, w_last;
  logic [IDXW-1:0]   r_owner, w_owner;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [NREQ-1:0]   w_grant, w_ack, w_err;
  logic [DBIT-1:0]   w_tx_din;
  logic              w_tx_start;
  logic              w_found;
  logic [IDXW-1:0]   w_win;
  int                w_idx;

  // Search starts just after the previous owner so it drops to lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_last) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDXW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state    = r_state;
    w_last     = r_last;
    w_owner    = r_owner;
    w_cnt      = r_cnt;
    w_grant    = grant;
    w_tx_din   = tx_din;
    w_tx_start = 1'b0;
    w_ack      = '0;
    w_err      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner    = w_win;
          w_grant    = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_tx_din   = din[w_win*DBIT +: DBIT];
          w_tx_start = 1'b1;
          w_cnt      = '0;
          w_state    = S_START;
        end
      end
      S_START: w_state = S_WAIT;
      S_WAIT: begin
        if (s_tick)
          w_cnt = r_cnt + CW'(1);
        // Completion takes precedence over a coinciding watchdog expiry.
        if (tx_din_done) begin
          w_ack   = grant;
          w_state = S_DONE;
        end else if (s_tick && (r_cnt == C_CNT_LAST)) begin
          w_err   = grant;
          w_state = S_DONE;
        end
      end
      S_DONE: begin
        w_last  = r_owner;
        w_grant = '0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= IDXW'(NREQ - 1);
      r_owner  <= '0;
      r_cnt    <= '0;
      grant    <= '0;
      tx_din   <= '0;
      tx_start <= 1'b0;
      ack      <= '0;
      err      <= '0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_owner  <= w_owner;
      r_cnt    <= w_cnt;
      grant    <= w_grant;
      tx_din   <= w_tx_din;
      tx_start <= w_tx_start;
      ack      <= w_ack;
      err      <= w_err;
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Purpose : Directed vector table plus corner sequences for uart_tx_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        s_tick;
  logic        tx_din_done;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic [3:0]  grant, ack, err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TO_TICKS(200)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .s_tick(s_tick),
    .tx_din_done(tx_din_done), .tx_start(tx_start), .tx_din(tx_din),
    .grant(grant), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       start;
    logic [3:0] ack;
    logic       busy;
    logic [7:0] txd;
  } vec_t;

  vec_t vecs[25];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Outputs packed as {grant, ack, err, tx_start, busy, tx_din}.
  function automatic logic [63:0] outs();
    return {42'd0, grant, ack, err, tx_start, busy, tx_din};
  endfunction

  function automatic logic [63:0] mk(input logic [3:0] g, input logic [3:0] a,
                                     input logic [3:0] e, input logic s,
                                     input logic b, input logic [7:0] d);
    return {42'd0, g, a, e, s, b, d};
  endfunction

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!tx_start && n < 20) begin
      step();
      n++;
    end
    if (!tx_start) check({name, "_start_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic       early;

    // {req, done, grant, start, ack, busy, tx_din}
    vecs[0]  = '{4'b0001, 0, 4'b0001, 1, 4'b0000, 1, 8'hA5};
    vecs[1]  = '{4'b0001, 0, 4'b0001, 0, 4'b0000, 1, 8'hA5};
    vecs[2]  = '{4'b0001, 1, 4'b0001, 0, 4'b0001, 1, 8'hA5};
    vecs[3]  = '{4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 8'hA5};
    vecs[4]  = '{4'b1111, 0, 4'b0010, 1, 4'b0000, 1, 8'h22};
    vecs[5]  = '{4'b1111, 0, 4'b0010, 0, 4'b0000, 1, 8'h22};
    vecs[6]  = '{4'b1111, 1, 4'b0010, 0, 4'b0010, 1, 8'h22};
    vecs[7]  = '{4'b1101, 0, 4'b0000, 0, 4'b0000, 0, 8'h22};
    vecs[8]  = '{4'b1101, 0, 4'b0100, 1, 4'b0000, 1, 8'h33};
    vecs[9]  = '{4'b1101, 1, 4'b0100, 0, 4'b0000, 1, 8'h33};
    vecs[10] = '{4'b1101, 1, 4'b0100, 0, 4'b0100, 1, 8'h33};
    vecs[11] = '{4'b1001, 0, 4'b0000, 0, 4'b0000, 0, 8'h33};
    vecs[12] = '{4'b1001, 0, 4'b1000, 1, 4'b0000, 1, 8'h44};
    vecs[13] = '{4'b1001, 0, 4'b1000, 0, 4'b0000, 1, 8'h44};
    vecs[14] = '{4'b1001, 1, 4'b1000, 0, 4'b1000, 1, 8'h44};
    vecs[15] = '{4'b0001, 0, 4'b0000, 0, 4'b0000, 0, 8'h44};
    vecs[16] = '{4'b0001, 0, 4'b0001, 1, 4'b0000, 1, 8'hA5};
    vecs[17] = '{4'b0001, 0, 4'b0001, 0, 4'b0000, 1, 8'hA5};
    vecs[18] = '{4'b0001, 1, 4'b0001, 0, 4'b0001, 1, 8'hA5};
    vecs[19] = '{4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 8'hA5};
    vecs[20] = '{4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 8'hA5};
    vecs[21] = '{4'b0010, 0, 4'b0010, 1, 4'b0000, 1, 8'h22};
    vecs[22] = '{4'b0000, 0, 4'b0010, 0, 4'b0000, 1, 8'h22};
    vecs[23] = '{4'b0000, 1, 4'b0010, 0, 4'b0010, 1, 8'h22};
    vecs[24] = '{4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 8'h22};

    rst = 1'b1; req = '0; din = {8'h44, 8'h33, 8'h22, 8'hA5};
    s_tick = 1'b0; tx_din_done = 1'b0;
    step(); step();
    check("reset_outputs", outs(), mk(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 8'h00));
    rst = 1'b0;
    step();
    check("idle_after_reset", outs(), mk(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 8'h00));

    for (int i = 0; i < 25; i++) begin
      req = vecs[i].req;
      tx_din_done = vecs[i].done;
      step();
      check($sformatf("vec%0d", i), outs(),
            mk(vecs[i].grant, vecs[i].ack, 4'b0, vecs[i].start, vecs[i].busy, vecs[i].txd));
    end
    tx_din_done = 1'b0;

    // Fairness: 0 and 2 always requesting, starting from reset priority.
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0101;
    exp_g = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      wait_start("fair");
      check($sformatf("fair_grant%0d", t), {60'd0, grant}, {60'd0, exp_g});
      step();
      tx_din_done = 1'b1; step(); tx_din_done = 1'b0;
      check($sformatf("fair_ack%0d", t), {60'd0, ack}, {60'd0, exp_g});
      exp_g = (exp_g == 4'b0001) ? 4'b0100 : 4'b0001;
    end
    req = '0; step(); step();

    // Watchdog: ticks every other cycle, no completion.
    req = 4'b0100;
    wait_start("wd");
    req = 4'b0100;
    step();
    early = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      s_tick = 1'b0; step();
      if (err != 4'b0 || ack != 4'b0) early = 1'b1;
      s_tick = 1'b1; step();
      if (i < 200 && (err != 4'b0 || ack != 4'b0 || !busy)) early = 1'b1;
    end
    s_tick = 1'b0;
    check("wd_no_early_err", {63'd0, early}, 64'd0);
    check("wd_err", {56'd0, err, ack}, {56'd0, 4'b0100, 4'b0000});
    req = '0;
    step();
    check("wd_back_idle", {63'd0, busy}, 64'd0);

    // Completion on the final watchdog tick: ack only.
    req = 4'b0100;
    wait_start("wdc");
    step();
    for (int i = 1; i <= 200; i++) begin
      s_tick = 1'b1;
      tx_din_done = (i == 200);
      step();
    end
    s_tick = 1'b0; tx_din_done = 1'b0;
    check("coincide_ack_only", {56'd0, err, ack}, {56'd0, 4'b0000, 4'b0100});
    req = '0; step();

    // Asynchronous reset while waiting for completion.
    req = 4'b0010;
    wait_start("rst");
    step(); step();
    check("rst_pre_busy", {60'd0, grant, busy}, {60'd0, 4'b0010, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("rst_async", outs(), mk(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 8'h00));
    #1 rst = 1'b0;
    req = 4'b1111;
    step();
    check("rst_req0_first", {52'd0, grant, tx_din}, {52'd0, 4'b0001, 8'hA5});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
